// File: rtl/mem_port_arbiter.sv
// Byte-serial arbiter sharing one 8-bit memory port between IF and LSU.
// Optional UART-full write stall: define MEM_PORT_ARBITER_IOFULL_EN.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_abort,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_next;
    logic              owner_lsu;
    logic [ADDR_W-1:0] addr, addr_k;
    logic [31:0]       wdata, rbuf, buf_cap;
    logic [2:0]        k, km1, nbytes, lsu_n;
    logic              grant_lsu, grant_if, abort_if, stall;

    assign lsu_n    = (lsu_size == 2'b00) ? 3'd1 :
                      (lsu_size == 2'b01) ? 3'd2 : 3'd4;
    assign addr_k   = addr + ADDR_W'(k);
    assign abort_if = if_abort && !owner_lsu;
    assign km1      = k - 3'd1;

`ifdef MEM_PORT_ARBITER_IOFULL_EN
    // Only the UART window (a[17:16] == 3) backs off on a full buffer.
    assign stall = io_buffer_full && (addr_k[17:16] == 2'b11);
`else
    logic unused_io;
    assign unused_io = io_buffer_full;
    assign stall     = 1'b0;
`endif

    // Byte k-1 arrives one cycle after its address was issued.
    always_comb begin
        buf_cap = rbuf;
        if (k != 3'd0) begin
            buf_cap[{km1[1:0], 3'b000} +: 8] = mem_din;
        end
    end

    always_comb begin
        state_next = state;
        grant_lsu  = 1'b0;
        grant_if   = 1'b0;
        mem_a      = '0;
        mem_dout   = 8'h00;
        mem_wr     = 1'b0;
        if_done    = 1'b0;
        lsu_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (lsu_req) begin
                    grant_lsu  = 1'b1;
                    state_next = lsu_we ? WR : RD;
                end else if (if_req && !if_abort) begin
                    grant_if   = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                if (k < nbytes) mem_a = addr_k;
                if (k == nbytes) state_next = DONE;
                if (abort_if) state_next = IDLE;
            end
            WR: begin
                mem_a    = addr_k;
                mem_dout = wdata[{k[1:0], 3'b000} +: 8];
                mem_wr   = !stall;
                if (!stall && k == nbytes - 3'd1) state_next = DONE;
                if (abort_if) state_next = IDLE;
            end
            DONE: begin
                if_done    = !owner_lsu && !if_abort;
                lsu_done   = owner_lsu;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            addr      <= '0;
            wdata     <= 32'h0;
            nbytes    <= 3'd0;
            k         <= 3'd0;
            rbuf      <= 32'h0;
            if_data   <= 32'h0;
            lsu_rdata <= 32'h0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (grant_lsu || grant_if) begin
                        owner_lsu <= grant_lsu;
                        addr      <= grant_lsu ? lsu_addr : if_addr;
                        wdata     <= lsu_wdata;
                        nbytes    <= grant_lsu ? lsu_n : 3'd4;
                        k         <= 3'd0;
                        rbuf      <= 32'h0;
                    end
                end
                RD: begin
                    rbuf <= buf_cap;
                    if (k != nbytes) begin
                        k <= k + 3'd1;
                    end else if (!abort_if) begin
                        if (owner_lsu) lsu_rdata <= buf_cap;
                        else if_data <= buf_cap;
                    end
                end
                WR: begin
                    if (!stall) k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single byte-wide RAM/IO port of `riscv_top` between two requesters:
  - instruction fetch (IF): 32-bit reads only;
  - load/store unit (LSU): 1/2/4-byte reads and writes.
- Serialises each access into per-byte memory cycles and assembles or splits little-endian words.
- Sits between the CPU core and the memory/UART interface inside `riscv_top`.

## Interface

Parameters:
- `ADDR_W`, 32: address width of requests and of `mem_a`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF requests a 4-byte read at `if_addr`.
- `if_addr` in ADDR_W: IF byte address.
- `if_abort` in 1: cancel the in-flight IF access (pipeline flush).
- `if_done` out 1: one-cycle pulse; `if_data` is valid in the same cycle.
- `if_data` out 32: fetched word.
- `lsu_req` in 1: LSU access request.
- `lsu_we` in 1: 1 = write, 0 = read.
- `lsu_size` in 2: 00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
- `lsu_addr` in ADDR_W: LSU byte address.
- `lsu_wdata` in 32: store data; byte k is taken from bits [8k+7:8k].
- `lsu_done` out 1: one-cycle pulse; completes the LSU access.
- `lsu_rdata` out 32: load data, zero-extended above `size` bytes.
- `mem_din` in 8: read byte from memory; corresponds to the address driven in the previous cycle.
- `mem_dout` out 8: write byte to memory.
- `mem_a` out ADDR_W: memory byte address.
- `mem_wr` out 1: 1 = write cycle.
- `io_buffer_full` in 1: UART transmit buffer full.

## Operation

- States: IDLE, RD, WR, DONE.
- Arbitration happens in IDLE only.
  - If `lsu_req` is high, the LSU is granted (fixed LSU priority); otherwise `if_req` is granted.
  - The grant latches address, size, write data and owner.
- Byte counting:
  - N = 4 for IF; N is derived from `lsu_size` for the LSU.
  - The issue counter k runs 0..N-1 and drives `mem_a` = addr + k, with modulo-2^ADDR_W wrap.
- RD state:
  - Issues addresses for bytes 0..N-1 on consecutive cycles.
  - Captures `mem_din` one cycle after each address into byte lane k.
  - After the last capture, goes to DONE.
- WR state:
  - Drives `mem_wr`=1, `mem_a` = addr + k and `mem_dout` = wdata byte k for k = 0..N-1.
  - After the last byte, goes to DONE.
- DONE state:
  - Pulses the owner's done output for exactly one cycle.
  - Neither requester is granted in this cycle.
  - Goes to IDLE next cycle.
- Requester contract: hold `req` and its operands stable until done; deassert `req` in the cycle after done, or re-assert for a new access.
- `if_abort`:
  - In any non-IDLE cycle of an IF-owned access, terminates it with no `if_done`, returning to IDLE next cycle.
  - In IDLE, suppresses an IF grant that cycle.
  - Has no effect on LSU-owned accesses.
- Outputs when not in RD/WR: `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
- `if_data` and `lsu_rdata` hold their last values until the next completion.

## Timing

- Reset value of every output is 0; the state after reset is IDLE.
- Reset asserted mid-access aborts it immediately; no done pulse is issued after reset releases.
- Let t = the IDLE cycle in which the grant is sampled.
- Reads:
  - `mem_a` = addr+k in cycle t+1+k.
  - The byte is captured at the end of cycle t+2+k.
  - done is high in cycle t+N+2 (word: t+6; byte: t+3).
- Writes: `mem_wr`=1 in cycles t+1..t+N; done is high in cycle t+N+1.
- Earliest next grant is cycle done+1.
- Simultaneous `if_req` and `lsu_req` in IDLE: LSU wins; IF is granted at the first IDLE cycle without `lsu_req`.
- IF may starve under back-to-back LSU traffic. This is accepted, because the LSU stalls the core anyway.

## Configuration

- Macro `MEM_PORT_ARBITER_IOFULL_EN`.
- Defined:
  - In WR, if `io_buffer_full`=1 and `mem_a`[17:16]=2'b11, the current byte is not issued: `mem_wr`=0 and k is held.
  - The write retries each cycle until `io_buffer_full`=0.
  - Each stall cycle adds one cycle to done.
- Undefined: `io_buffer_full` is ignored and write timing is always as specified in Timing.

## Test plan

- Reset, then IF word read at 0x0000_0010 with RAM bytes 0x13, 0x05, 0x10, 0x00:
  - `mem_a` = 0x10..0x13 in cycles t+1..t+4;
  - `if_done` at t+6 with `if_data`=0x0010_0513.
- LSU half write at 0x0000_0100 with wdata 0xDEAD_BEEF:
  - `mem_wr`=1 with (0x100, 0xEF) then (0x101, 0xBE);
  - `lsu_done` at t+3;
  - LSU byte read at 0x100 returns `lsu_rdata`=0x0000_00EF.
- `if_req` and `lsu_req` rise in the same cycle:
  - LSU byte read completes first;
  - IF grant follows in the IDLE cycle after `lsu_done`;
  - exactly one done pulse per requester.
- `if_abort` asserted at t+3 of an IF read: no `if_done`, state IDLE at t+4, and a pending `lsu_req` is granted at t+4.
- With `MEM_PORT_ARBITER_IOFULL_EN`, byte write to 0x0003_0000 while `io_buffer_full`=1 for 3 cycles:
  - `mem_wr` stays 0 for those cycles, then pulses once;
  - `lsu_done` is 3 cycles later than the unstalled case.
  - Without the macro: no stall.
- `rst_n` dropped at t+2 of an LSU word write: all outputs 0 immediately, no `lsu_done`, and a new IF read completes normally after release.
